// File: rtl/key_scan_pkg.sv
// Shared types and constants for the push-button front end.
package key_scan_pkg;

    localparam int unsigned NUM_KEYS   = 5;
    localparam int unsigned KEY_CODE_W = 3;
    localparam logic [KEY_CODE_W-1:0] KEY_NONE = 3'd7;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CNT,
        PRESSED,
        RELEASE_CNT
    } deb_state_t;

    // Index of the lowest set bit, KEY_NONE when the mask is empty.
    function automatic logic [KEY_CODE_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] mask);
        lowest_idx = KEY_NONE;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_idx = KEY_CODE_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-FF synchroniser, debounce FSM and stability counter.
// Optional auto-repeat while held is built when KEY_REPEAT_EN is defined.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic pressed,
    output logic press_evt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             evt_nxt;
    logic             pressed_nxt;

`ifdef KEY_REPEAT_EN
    localparam int unsigned RPT_W = $clog2(REPEAT_DELAY) + 1;
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rcnt;
    logic [RPT_W-1:0] rcnt_nxt;
`endif

    // Bring the asynchronous button level into the clk domain; idle is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key;
            sync_q2 <= sync_q1;
        end
    end

    // Debounce state, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RELEASED;
            cnt       <= '0;
            pressed   <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pressed   <= pressed_nxt;
            press_evt <= evt_nxt;
        end
    end

    // Next-state: a level change is accepted after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        evt_nxt   = 1'b0;
        unique case (state)
            RELEASED: begin
                if (!sync_q2) begin
                    state_nxt = PRESS_CNT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS_CNT: begin
                if (sync_q2) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    evt_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync_q2) begin
                    state_nxt = RELEASE_CNT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            RELEASE_CNT: begin
                if (!sync_q2) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase

`ifdef KEY_REPEAT_EN
        // Auto-repeat only while the key stays in PRESSED; any exit clears the counter.
        rcnt_nxt = '0;
        if (state == PRESSED && state_nxt == PRESSED) begin
            if (rcnt == RPT_LAST) begin
                evt_nxt  = 1'b1;
                rcnt_nxt = RPT_RELOAD;
            end else begin
                rcnt_nxt = rcnt + RPT_W'(1);
            end
        end
`endif

        pressed_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_CNT);
    end

`ifdef KEY_REPEAT_EN
    // Hold-time counter for auto-repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_nxt;
        end
    end
`endif

endmodule

// File: rtl/key_scan_debounce.sv
// Five-button front end: per-key debounce plus a lowest-index-first press event arbiter.
// Build option: define KEY_REPEAT_EN to add auto-repeat events while a key is held.
module key_scan_debounce
    import key_scan_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
`ifdef KEY_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25_000_000,
    parameter int unsigned REPEAT_PERIOD   = 5_000_000
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_KEYS-1:0]   key,
    output logic [NUM_KEYS-1:0]   key_pressed,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic [KEY_CODE_W-1:0] last_code
);

    logic [NUM_KEYS-1:0]   pressed_w;
    logic [NUM_KEYS-1:0]   evt_w;
    logic [NUM_KEYS-1:0]   pending;
    logic [NUM_KEYS-1:0]   pending_nxt;
    logic [NUM_KEYS-1:0]   grant;
    logic [KEY_CODE_W-1:0] win_idx;
    logic                  win_any;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_REPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_deb (
            .clk       (clk),
            .rst_n     (rst_n),
            .key       (key[i]),
            .pressed   (pressed_w[i]),
            .press_evt (evt_w[i])
        );
    end

    // Pick the lowest pending key; fresh events merge into the pending mask.
    always_comb begin
        win_any     = |pending;
        win_idx     = lowest_idx(pending);
        grant       = '0;
        if (win_any) begin
            grant = NUM_KEYS'(1) << win_idx;
        end
        pending_nxt = (pending | evt_w) & ~grant;
    end

    // Output registers and pending mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_pressed <= '0;
            pending     <= '0;
            key_valid   <= 1'b0;
            key_code    <= KEY_NONE;
            last_code   <= KEY_NONE;
        end else begin
            key_pressed <= pressed_w;
            pending     <= pending_nxt;
            key_valid   <= win_any;
            key_code    <= win_any ? win_idx : KEY_NONE;
            if (win_any) begin
                last_code <= win_idx;
            end
        end
    end

endmodule
